demux14_router: RTL and testbench
=================================

// Module: demux14_router
//
// PURPOSE
//   Registered 1:4 demultiplexer. The counterpart of the 4:1 mux family.
//   - Steers one input stream to one of four output channels, selected per beat by sel.
//   - Each channel has a one-entry output register and a valid/ready handshake.
//   - Each channel keeps a wrap-around count of accepted beats.
//   - Sits between a single producer and four independent consumers.
//
// PARAMETERS
//   WIDTH  8  data width of input and each output channel
//   CNT_W  8  width of each per-channel beat counter
//
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous reset, active-low
//   in_data    in   WIDTH  input beat
//   in_valid   in   1      input beat present
//   in_ready   out  1      block accepts the input beat this cycle
//   sel        in   2      destination channel; {s1,s0}: 00->o0, 01->o1, 10->o2, 11->o3
//   oK_data    out  WIDTH  channel K data, K=0..3 (four ports)
//   oK_valid   out  1      channel K holds a beat, K=0..3
//   oK_ready   in   1      consumer K takes the beat, K=0..3
//   oK_cnt     out  CNT_W  beats accepted for channel K, K=0..3
//
// BEHAVIOUR
//   - Reset (rst_n low, asynchronous):
//       - all oK_valid=0, oK_data=0, oK_cnt=0.
//       - in_ready is forced 0 while rst_n is low.
//   - Drain: channel K drains when oK_valid & oK_ready at a clock edge.
//   - in_ready (combinational) = ~o[sel]_valid | o[sel]_ready.
//       - It depends only on the selected channel.
//       - Other channels never stall the input.
//   - Accept: a beat is accepted when in_valid & in_ready at a clock edge.
//       - On acceptance, slot[sel] <= in_data and o[sel]_valid <= 1.
//       - Latency is exactly 1 cycle: the beat is visible on o[sel] at the next cycle.
//   - Hold: while oK_valid=1 and oK_ready=0, oK_data and oK_valid stay stable.
//   - Drain without accept: when channel K drains and no new beat is accepted for K,
//     oK_valid <= 0. oK_data keeps its last value (don't-care when invalid).
//   - Same-cycle accept and drain on channel K:
//       - The slot reloads with the new beat.
//       - oK_valid stays 1, giving full throughput (1 beat/cycle per channel).
//   - Channel independence: all four channels drain in parallel in the same cycle.
//     Only one channel can be loaded per cycle.
//   - sel may change while in_valid=1 and no acceptance has occurred.
//     in_ready re-evaluates against the current sel every cycle; no sel is latched.
//   - Counters:
//       - oK_cnt increments by 1 on each accept to channel K.
//       - Modulo 2^CNT_W: it wraps 2^CNT_W-1 -> 0 and has no saturation.
//   - Reset mid-operation:
//       - Held beats are discarded and no output handshake completes.
//       - After release, all channels are empty and in_ready=1.
//   - in_valid=0: no state change except drains.
//
// STRUCTURE
//   - Package demux_pkg:
//       - NUM_CH=4, SEL_W=2.
//       - Channel index constants CH0..CH3.
//   - Sub-module demux_slot (instantiated 4x):
//       - One-entry register: load, drain, valid, data.
//       - Includes the CNT_W beat counter.
//       - Same async active-low reset.
//   - Top level: sel decode to a one-hot load vector, plus in_ready mux.
//
// TESTING
//   1. Reset:
//      - rst_n=0 -> all oK_valid=0, oK_cnt=0, in_ready=0.
//      - Release -> in_ready=1.
//   2. Single beat, sel=2'b10, in_data=8'hA5, o2_ready=1:
//      - Next cycle o2_valid=1 and o2_data=8'hA5; o0/o1/o3_valid=0.
//      - o2_cnt=1; o2_valid=0 one cycle later.
//   3. Backpressure, sel=2'b01, o1_ready=0, beats 8'h11 then 8'h22:
//      - in_ready=0 after the first beat; o1_data holds 8'h11.
//      - Raise o1_ready: 8'h11 drains and 8'h22 is accepted the same cycle.
//      - 8'h22 is visible next cycle.
//   4. Round-robin:
//      - sel=0,1,2,3 on consecutive cycles, all ready=1, in_valid=1.
//      - in_ready stays 1; each channel shows its beat one cycle after acceptance.
//      - Each oK_cnt=1.
//   5. Counter wrap: 256 beats to sel=2'b11 with o3_ready=1 -> o3_cnt returns to 0.
//   6. Reset mid-operation:
//      - Fill o0..o3 with all ready=0, then pulse rst_n=0.
//      - All valids drop immediately; no beat appears after release.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1:4 registered demultiplexer: channel count,
// select width, channel indices and the select-to-one-hot decode.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [NUM_CH-1:0] ch_vec_t;
  typedef logic [SEL_W-1:0]  ch_sel_t;

  localparam ch_sel_t CH0 = 2'd0;
  localparam ch_sel_t CH1 = 2'd1;
  localparam ch_sel_t CH2 = 2'd2;
  localparam ch_sel_t CH3 = 2'd3;

  function automatic ch_vec_t sel_onehot(input ch_sel_t s);
    ch_vec_t v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux14_router_if.sv
// Bundle of the producer-side stream and the four consumer-side channels
// of demux14_router. The slave view belongs to the router itself.
interface demux14_router_if import demux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  ch_sel_t          sel;

  logic [WIDTH-1:0] o0_data, o1_data, o2_data, o3_data;
  logic             o0_valid, o1_valid, o2_valid, o3_valid;
  logic             o0_ready, o1_ready, o2_ready, o3_ready;
  logic [CNT_W-1:0] o0_cnt, o1_cnt, o2_cnt, o3_cnt;

  modport slave (
    input  in_data, in_valid, sel,
    input  o0_ready, o1_ready, o2_ready, o3_ready,
    output in_ready,
    output o0_data, o1_data, o2_data, o3_data,
    output o0_valid, o1_valid, o2_valid, o3_valid,
    output o0_cnt, o1_cnt, o2_cnt, o3_cnt
  );

  modport master (
    output in_data, in_valid, sel,
    output o0_ready, o1_ready, o2_ready, o3_ready,
    input  in_ready,
    input  o0_data, o1_data, o2_data, o3_data,
    input  o0_valid, o1_valid, o2_valid, o3_valid,
    input  o0_cnt, o1_cnt, o2_cnt, o3_cnt
  );

endinterface

// File: rtl/demux_slot.sv
// One output channel: a single-entry data register with valid/ready drain
// and a wrap-around count of beats loaded into it.
module demux_slot #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: registered state uses non-blocking assignments so every slot
  // samples the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset as well, so a freshly reset
      // channel presents zero rather than a stale beat.
      valid <= 1'b0;
      data  <= '0;
      cnt   <= '0;
    end else if (load) begin
      // Covers both a plain load and a same-cycle drain+reload.
      valid <= 1'b1;
      data  <= load_data;
      cnt   <= cnt + CNT_W'(1);
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux14_router.sv
// Registered 1:4 demultiplexer: steers each accepted input beat into the
// one-entry slot picked by sel; the four slots drain independently.
module demux14_router import demux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  demux14_router_if.slave   bus
);

  ch_vec_t          ready_v;
  ch_vec_t          valid_v;
  ch_vec_t          load_v;
  logic [WIDTH-1:0] data_v [NUM_CH];
  logic [CNT_W-1:0] cnt_v  [NUM_CH];
  logic             accept;

  assign ready_v = {bus.o3_ready, bus.o2_ready, bus.o1_ready, bus.o0_ready};

  // Only the selected channel can stall the producer; a full slot still
  // accepts if it drains on the same edge. Held low throughout reset.
  assign bus.in_ready = rst_n & (~valid_v[bus.sel] | ready_v[bus.sel]);
  assign accept       = bus.in_valid & bus.in_ready;
  assign load_v       = accept ? sel_onehot(bus.sel) : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_v[k]),
      .load_data (bus.in_data),
      .ready     (ready_v[k]),
      .valid     (valid_v[k]),
      .data      (data_v[k]),
      .cnt       (cnt_v[k])
    );
  end

  assign bus.o0_valid = valid_v[CH0];
  assign bus.o1_valid = valid_v[CH1];
  assign bus.o2_valid = valid_v[CH2];
  assign bus.o3_valid = valid_v[CH3];

  assign bus.o0_data  = data_v[CH0];
  assign bus.o1_data  = data_v[CH1];
  assign bus.o2_data  = data_v[CH2];
  assign bus.o3_data  = data_v[CH3];

  assign bus.o0_cnt   = cnt_v[CH0];
  assign bus.o1_cnt   = cnt_v[CH1];
  assign bus.o2_cnt   = cnt_v[CH2];
  assign bus.o3_cnt   = cnt_v[CH3];

endmodule

// File: tb/tb_demux14_router.sv
// Directed bench for demux14_router: reset, single beat, backpressure,
// round-robin, back-to-back, counter wrap and reset mid-operation.
module tb_demux14_router;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux14_router_if #(.WIDTH(8), .CNT_W(8)) bus ();

  demux14_router #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] valids();
    return {bus.o3_valid, bus.o2_valid, bus.o1_valid, bus.o0_valid};
  endfunction

  function automatic logic [7:0] data_of(input int k);
    case (k)
      0:       return bus.o0_data;
      1:       return bus.o1_data;
      2:       return bus.o2_data;
      default: return bus.o3_data;
    endcase
  endfunction

  function automatic logic [7:0] cnt_of(input int k);
    case (k)
      0:       return bus.o0_cnt;
      1:       return bus.o1_cnt;
      2:       return bus.o2_cnt;
      default: return bus.o3_cnt;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic [3:0] r);
    bus.o0_ready = r[0];
    bus.o1_ready = r[1];
    bus.o2_ready = r[2];
    bus.o3_ready = r[3];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (valids() !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b want 0000", valids());
    end
    checks++;
    if ({bus.o3_cnt, bus.o2_cnt, bus.o1_cnt, bus.o0_cnt} !== 32'h0) begin
      errors++; $display("FAIL reset_cnt: got %h want 0", {bus.o3_cnt, bus.o2_cnt, bus.o1_cnt, bus.o0_cnt});
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low: got %b want 0", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single_beat();
    set_ready(4'b0100);
    bus.sel      = 2'b10;
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (valids() !== 4'b0100) begin
      errors++; $display("FAIL single_valids: got %b want 0100", valids());
    end
    checks++;
    if (bus.o2_data !== 8'hA5) begin
      errors++; $display("FAIL single_data: got %h want a5", bus.o2_data);
    end
    checks++;
    if (bus.o2_cnt !== 8'd1) begin
      errors++; $display("FAIL single_cnt: got %0d want 1", bus.o2_cnt);
    end
    tick();
    checks++;
    if (valids() !== 4'b0000) begin
      errors++; $display("FAIL single_drained: got %b want 0000", valids());
    end
    checks++;
    if (bus.o2_data !== 8'hA5) begin
      errors++; $display("FAIL single_data_kept: got %h want a5", bus.o2_data);
    end
  endtask

  task automatic test_backpressure();
    set_ready(4'b0000);
    bus.sel      = 2'b01;
    bus.in_data  = 8'h11;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data = 8'h22;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall: in_ready got %b want 0", bus.in_ready);
    end
    bus.sel = 2'b00;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_other_channel: in_ready got %b want 1", bus.in_ready);
    end
    bus.sel = 2'b01;
    tick();
    checks++;
    if (bus.o1_valid !== 1'b1 || bus.o1_data !== 8'h11 || bus.o1_cnt !== 8'd1) begin
      errors++; $display("FAIL bp_hold: got v=%b d=%h c=%0d want v=1 d=11 c=1",
                         bus.o1_valid, bus.o1_data, bus.o1_cnt);
    end
    bus.o1_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: in_ready got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.o1_valid !== 1'b1 || bus.o1_data !== 8'h22 || bus.o1_cnt !== 8'd2) begin
      errors++; $display("FAIL bp_reload: got v=%b d=%h c=%0d want v=1 d=22 c=2",
                         bus.o1_valid, bus.o1_data, bus.o1_cnt);
    end
    tick();
    checks++;
    if (bus.o1_valid !== 1'b0) begin
      errors++; $display("FAIL bp_final_drain: got %b want 0", bus.o1_valid);
    end
    set_ready(4'b0000);
  endtask

  task automatic test_round_robin();
    do_reset();
    set_ready(4'b1111);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.sel     = 2'(i);
      bus.in_data = 8'(8'h30 + i);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL rr_in_ready ch%0d: got %b want 1", i, bus.in_ready);
      end
      tick();
      checks++;
      if (valids() !== 4'(1 << i) || data_of(i) !== 8'(8'h30 + i)) begin
        errors++; $display("FAIL rr_out ch%0d: got v=%b d=%h want v=%b d=%h",
                           i, valids(), data_of(i), 4'(1 << i), 8'(8'h30 + i));
      end
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt_of(i) !== 8'd1) begin
        errors++; $display("FAIL rr_cnt ch%0d: got %0d want 1", i, cnt_of(i));
      end
    end
    tick();
    checks++;
    if (valids() !== 4'b0000) begin
      errors++; $display("FAIL rr_drained: got %b want 0000", valids());
    end
  endtask

  task automatic test_back_to_back();
    set_ready(4'b1111);
    bus.sel      = 2'b00;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'(8'h50 + i);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_in_ready beat%0d: got %b want 1", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.o0_valid !== 1'b1 || bus.o0_data !== 8'(8'h50 + i)) begin
        errors++; $display("FAIL b2b_out beat%0d: got v=%b d=%h want v=1 d=%h",
                           i, bus.o0_valid, bus.o0_data, 8'(8'h50 + i));
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.o0_cnt !== 8'd5) begin
      errors++; $display("FAIL b2b_cnt: got %0d want 5", bus.o0_cnt);
    end
    tick();
  endtask

  task automatic test_counter_wrap();
    int stalls;
    do_reset();
    set_ready(4'b1000);
    bus.sel      = 2'b11;
    bus.in_valid = 1'b1;
    stalls       = 0;
    for (int i = 0; i < 255; i++) begin
      bus.in_data = 8'(i);
      #1;
      if (bus.in_ready !== 1'b1) stalls++;
      tick();
    end
    checks++;
    if (stalls != 0) begin
      errors++; $display("FAIL wrap_stalls: got %0d want 0", stalls);
    end
    checks++;
    if (bus.o3_cnt !== 8'd255) begin
      errors++; $display("FAIL wrap_cnt_max: got %0d want 255", bus.o3_cnt);
    end
    bus.in_data = 8'hEE;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.o3_cnt !== 8'd0 || bus.o3_valid !== 1'b1 || bus.o3_data !== 8'hEE) begin
      errors++; $display("FAIL wrap_cnt_zero: got c=%0d v=%b d=%h want c=0 v=1 d=ee",
                         bus.o3_cnt, bus.o3_valid, bus.o3_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_ready(4'b0000);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.sel     = 2'(k);
      bus.in_data = 8'(8'hC0 + k);
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (valids() !== 4'b1111 || bus.o3_data !== 8'hC3) begin
      errors++; $display("FAIL mid_filled: got v=%b d3=%h want v=1111 d3=c3", valids(), bus.o3_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valids() !== 4'b0000 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_async_drop: got v=%b rdy=%b want v=0000 rdy=0", valids(), bus.in_ready);
    end
    checks++;
    if (bus.o2_data !== 8'h00 || bus.o1_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_async_clear: got d2=%h c1=%0d want d2=00 c1=0", bus.o2_data, bus.o1_cnt);
    end
    set_ready(4'b1111);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_release_ready: got %b want 1", bus.in_ready);
    end
    tick();
    tick();
    checks++;
    if (valids() !== 4'b0000) begin
      errors++; $display("FAIL mid_no_ghost_beat: got %b want 0000", valids());
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.sel      = '0;
    set_ready(4'b0000);

    test_reset();
    test_single_beat();
    test_backpressure();
    test_round_robin();
    test_back_to_back();
    test_counter_wrap();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
